reg_share_arbiter: RTL and testbench

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_share_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter guarding one shared W-bit register.
// Each grant lasts one cycle; the granted requester's data is written if it still requests.
module reg_share_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   grant,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [IW-1:0]  owner,
  output logic [7:0]     wr_count,
  output logic           busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]    q_q, q_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      count_q, count_d;

  logic            found;
  logic [IW-1:0]   win;
  int unsigned     idx;
  logic            win_req;
  logic [W-1:0]    win_data;

  // Upward search from ptr with wrap; first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  // grant_q is one-hot in StGrant, so masking selects the winner's request and data.
  always_comb begin
    win_req  = |(req & grant_q);
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        win_data = wdata[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    winner_d = winner_q;
    ptr_d    = ptr_q;
    q_d      = q_q;
    valid_d  = valid_q;
    owner_d  = owner_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StGrant;
          winner_d = win;
          grant_d  = {{(N-1){1'b0}}, 1'b1} << win;
        end
      end
      StGrant: begin
        state_d = StIdle;
        if (win_req) begin
          q_d     = win_data;
          owner_d = winner_q;
          valid_d = 1'b1;
          count_d = count_q + 8'd1;
          ptr_d   = (winner_q == IW'(N - 1)) ? '0 : winner_q + IW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      winner_q <= '0;
      ptr_q    <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      owner_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
    end
  end

  assign grant    = grant_q;
  assign q        = q_q;
  assign q_valid  = valid_q;
  assign owner    = owner_q;
  assign wr_count = count_q;
  assign busy     = (state_q == StGrant);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (N=4, W=8) with hand-computed expectations.
module tb_reg_share_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   grant;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [1:0]     owner;
  logic [7:0]     wr_count;
  logic           busy;

  int total;
  int bad;

  reg_share_arbiter #(.N(N), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wdata    (wdata),
    .grant    (grant),
    .q        (q),
    .q_valid  (q_valid),
    .owner    (owner),
    .wr_count (wr_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic check_reg(input string tag, input logic [7:0] eq, input logic ev,
                           input logic [1:0] eo, input logic [7:0] ec);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(ev));
    check({tag, ".owner"}, 32'(owner), 32'(eo));
    check({tag, ".wr_count"}, 32'(wr_count), 32'(ec));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [3:0] exp_seq [8];
  logic [7:0] last_data;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req   = '0;
    wdata = '0;
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};

    do_reset();
    check("rst.grant", 32'(grant), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check_reg("rst", 8'h00, 1'b0, 2'd0, 8'd0);

    // Single requester write
    wdata[7:0] = 8'hA5;
    req = 4'b0001;
    step();
    check("single.grant", 32'(grant), 32'h1);
    check("single.busy", 32'(busy), 32'd1);
    check_reg("single.pre", 8'h00, 1'b0, 2'd0, 8'd0);
    step();
    req = 4'b0000;
    check("single.grant_off", 32'(grant), 32'h0);
    check_reg("single", 8'hA5, 1'b1, 2'd0, 8'd1);

    // All requesting from ptr 0: rotation 0,1,2,3
    do_reset();
    wdata = 32'h44332211;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("rot.grant%0d", i), 32'(grant), 32'(exp_seq[i]));
    end
    req = 4'b0000;
    check_reg("rot", 8'h44, 1'b1, 2'd3, 8'd4);

    // Abort: requester 2 drops during its grant cycle
    req = 4'b0100;
    step();
    check("abort.grant", 32'(grant), 32'h4);
    req = 4'b0000;
    step();
    check("abort.grant_off", 32'(grant), 32'h0);
    check("abort.busy", 32'(busy), 32'd0);
    check_reg("abort", 8'h44, 1'b1, 2'd3, 8'd4);
    req = 4'b0100;
    step();
    check("abort.regrant", 32'(grant), 32'h4);
    step();
    req = 4'b0000;
    check_reg("abort.rewrite", 8'h33, 1'b1, 2'd2, 8'd5);

    // Requester 1 writes (ptr -> 2); then 0 and 1 request: wrap picks 0
    req = 4'b0010;
    step();
    check("wrap.g1", 32'(grant), 32'h2);
    step();
    check_reg("wrap.w1", 8'h22, 1'b1, 2'd1, 8'd6);
    req = 4'b0011;
    step();
    check("wrap.grant", 32'(grant), 32'h1);
    step();
    req = 4'b0000;
    check_reg("wrap.w0", 8'h11, 1'b1, 2'd0, 8'd7);

    // Reset during a GRANT with req held discards the write
    wdata[7:0] = 8'h5A;
    req = 4'b0001;
    step();
    check("rstg.grant", 32'(grant), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstg.grant_off", 32'(grant), 32'h0);
    check("rstg.busy", 32'(busy), 32'd0);
    check_reg("rstg", 8'h00, 1'b0, 2'd0, 8'd0);
    step();
    check("rstg.rearb", 32'(grant), 32'h1);
    step();
    check_reg("rstg.write", 8'h5A, 1'b1, 2'd0, 8'd1);

    // 255 more writes from requester 0: count wraps to 0
    last_data = 8'h00;
    for (int i = 0; i < 255; i++) begin
      last_data = 8'(i) ^ 8'h3C;
      wdata[7:0] = last_data;
      step();
      check("wrap256.grant", 32'(grant), 32'h1);
      step();
    end
    req = 4'b0000;
    check_reg("wrap256", last_data, 1'b1, 2'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
